// File: rtl/ti_fetch_responder_pkg.sv
// Shared T&I fetch definitions: widths, fetch sizes, FSM state type and request record.
package VX_ti_pkg;

  localparam int ADDR_WIDTH      = 32;
  localparam int WORD_BYTES      = 4;
  localparam int MAX_BYTES       = 48;
  localparam int MAX_OUTSTANDING = 4;

  localparam int NUM_WORDS = MAX_BYTES / WORD_BYTES;
  localparam int TAG_W     = $clog2(NUM_WORDS);
  localparam int SIZE_W    = $clog2(MAX_BYTES + 1);
  localparam int OFF_W     = $clog2(WORD_BYTES);
  localparam int WORD_BITS = WORD_BYTES * 8;

  localparam int BVH_NODE_BYTES  = 32;
  localparam int TRI_INDEX_BYTES = 4;
  localparam int TRI_NODE_BYTES  = 48;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_ISSUE,
    FETCH_DONE
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [SIZE_W-1:0]     size;
  } ti_fetch_req_t;

  // Number of memory words needed to cover nbytes (nbytes is already clamped).
  function automatic logic [SIZE_W-1:0] words_for(input logic [SIZE_W-1:0] nbytes);
    logic [SIZE_W:0] padded;
    padded = {1'b0, nbytes} + (SIZE_W + 1)'(WORD_BYTES - 1);
    return SIZE_W'(padded >> OFF_W);
  endfunction

endpackage

// File: rtl/ti_fetch_assembler.sv
// Reassembles tagged, possibly out-of-order response words into the wide fetch buffer.
module ti_fetch_assembler
  import VX_ti_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   active,
  input  logic [SIZE_W-1:0]      nwords,
  input  logic [SIZE_W-1:0]      size,
  input  logic                   rsp_valid,
  input  logic [TAG_W-1:0]       rsp_tag,
  input  logic [WORD_BITS-1:0]   rsp_data,
  output logic                   accept,
  output logic [SIZE_W-1:0]      received,
  output logic [MAX_BYTES*8-1:0] data
);

  logic [NUM_WORDS-1:0]                mask_reg;
  logic [NUM_WORDS-1:0]                word_sel;
  logic [MAX_BYTES-1:0]                byte_keep;
  logic [SIZE_W-1:0]                   received_reg;
  logic [NUM_WORDS-1:0][WORD_BITS-1:0] data_reg;
  logic [NUM_WORDS-1:0][WORD_BITS-1:0] word_in;
  logic                                tag_in_range;

  // One-hot word select from the tag, and a keep flag for every byte inside the clamped size.
  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      assign word_sel[gi] = (rsp_tag == TAG_W'(gi));
      for (genvar bi = 0; bi < WORD_BYTES; bi++) begin : g_byte
        assign byte_keep[gi*WORD_BYTES+bi] = (SIZE_W'(gi*WORD_BYTES+bi) < size);
      end
    end
  endgenerate

  assign tag_in_range = (SIZE_W'(rsp_tag) < nwords);
  // Duplicates and tags past the fetch length are silently dropped.
  assign accept       = active && rsp_valid && tag_in_range && ((word_sel & mask_reg) == '0);
  assign received     = received_reg;
  assign data         = data_reg;

  // Zero the bytes of the tail word that lie beyond the requested length.
  always_comb begin
    word_in = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        word_in[w][b*8 +: 8] = byte_keep[w*WORD_BYTES+b] ? rsp_data[b*8 +: 8] : 8'h00;
      end
    end
  end

  // Track which words have arrived and how many.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_reg     <= '0;
      received_reg <= '0;
    end else if (clear) begin
      mask_reg     <= '0;
      received_reg <= '0;
    end else if (accept) begin
      mask_reg     <= mask_reg | word_sel;
      received_reg <= received_reg + SIZE_W'(1);
    end
  end

  // Store accepted words; the buffer then holds until the next fetch starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg <= '0;
    end else if (clear) begin
      data_reg <= '0;
    end else if (accept) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        if (word_sel[w]) data_reg[w] <= word_in[w];
      end
    end
  end

endmodule

// File: rtl/ti_fetch_responder.sv
// T&I fetch responder: splits a fetch into word reads, limits reads in flight, signals completion.
module ti_fetch_responder
  import VX_ti_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [SIZE_W-1:0]      mem_size,
  output logic                   ready_out,
  output logic                   valid_out,
  output logic                   err_out,
  output logic [MAX_BYTES*8-1:0] mem_data,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr,
  output logic [TAG_W-1:0]       mem_req_tag,
  input  logic                   mem_rsp_valid,
  input  logic [WORD_BITS-1:0]   mem_rsp_data,
  input  logic [TAG_W-1:0]       mem_rsp_tag,
  output logic                   mem_rsp_ready
);

  fetch_state_t      state_reg, state_next;
  ti_fetch_req_t     req_reg;
  logic [SIZE_W-1:0] nwords_reg;
  logic [SIZE_W-1:0] issued_reg;
  logic              err_reg;

  logic              accept_start;
  logic [SIZE_W-1:0] clamped_size;
  logic [SIZE_W-1:0] start_nwords;
  logic [SIZE_W-1:0] in_flight;
  logic [SIZE_W-1:0] received;
  logic              rsp_accept;

  assign accept_start = (state_reg == FETCH_IDLE) && start;
  assign clamped_size = (mem_size > SIZE_W'(MAX_BYTES)) ? SIZE_W'(MAX_BYTES) : mem_size;
  assign start_nwords = words_for(clamped_size);
  assign in_flight    = issued_reg - received;

  // Request stays up once raised: in_flight can only shrink while it waits for ready.
  assign mem_req_valid = (state_reg == FETCH_ISSUE) && (issued_reg < nwords_reg) &&
                         (in_flight < SIZE_W'(MAX_OUTSTANDING));
  assign mem_req_addr  = req_reg.addr + (ADDR_WIDTH'(issued_reg) << OFF_W);
  assign mem_req_tag   = TAG_W'(issued_reg);
  assign mem_rsp_ready = 1'b1;

  assign ready_out = (state_reg == FETCH_IDLE);
  assign valid_out = (state_reg == FETCH_DONE);
  assign err_out   = (state_reg == FETCH_DONE) && err_reg;

  ti_fetch_assembler u_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept_start),
    .active    (state_reg == FETCH_ISSUE),
    .nwords    (nwords_reg),
    .size      (req_reg.size),
    .rsp_valid (mem_rsp_valid),
    .rsp_tag   (mem_rsp_tag),
    .rsp_data  (mem_rsp_data),
    .accept    (rsp_accept),
    .received  (received),
    .data      (mem_data)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= FETCH_IDLE;
    else       state_reg <= state_next;
  end

  // Next state: leave ISSUE in the cycle the last outstanding word arrives.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH_IDLE:  if (start) state_next = (start_nwords == '0) ? FETCH_DONE : FETCH_ISSUE;
      FETCH_ISSUE: if (received + SIZE_W'(rsp_accept) == nwords_reg) state_next = FETCH_DONE;
      FETCH_DONE:  state_next = FETCH_IDLE;
      default:     state_next = FETCH_IDLE;
    endcase
  end

  // Latch the request on start and count issued reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_reg    <= '0;
      nwords_reg <= '0;
      err_reg    <= 1'b0;
      issued_reg <= '0;
    end else if (accept_start) begin
      req_reg.addr <= {mem_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
      req_reg.size <= clamped_size;
      nwords_reg   <= start_nwords;
      err_reg      <= (mem_size > SIZE_W'(MAX_BYTES)) || (mem_addr[OFF_W-1:0] != '0);
      issued_reg   <= '0;
    end else if (mem_req_valid && mem_req_ready) begin
      issued_reg <= issued_reg + SIZE_W'(1);
    end
  end

endmodule

// File: tb/tb_ti_fetch_responder.sv
// Scoreboard bench for ti_fetch_responder with a tagged memory model.
module tb_ti_fetch_responder;
  import VX_ti_pkg::*;

  localparam int DW = MAX_BYTES * 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic [ADDR_WIDTH-1:0] mem_addr = '0;
  logic [SIZE_W-1:0]     mem_size = '0;
  logic                  ready_out, valid_out, err_out;
  logic [DW-1:0]         mem_data;
  logic                  mem_req_valid;
  logic                  mem_req_ready = 1'b0;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [TAG_W-1:0]      mem_req_tag;
  logic                  mem_rsp_valid = 1'b0;
  logic [WORD_BITS-1:0]  mem_rsp_data = '0;
  logic [TAG_W-1:0]      mem_rsp_tag = '0;
  logic                  mem_rsp_ready;

  always #5 clk = ~clk;

  ti_fetch_responder dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .mem_addr      (mem_addr),
    .mem_size      (mem_size),
    .ready_out     (ready_out),
    .valid_out     (valid_out),
    .err_out       (err_out),
    .mem_data      (mem_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_tag   (mem_req_tag),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_tag   (mem_rsp_tag),
    .mem_rsp_ready (mem_rsp_ready)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    logic [31:0]   base;
    int            nwords;
  } exp_t;

  typedef struct {
    logic [31:0]      addr;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } rsp_t;

  exp_t sb[$];
  req_t pending[$];
  req_t stale_q[$];
  rsp_t inj_q[$];

  int checks_total  = 0;
  int checks_passed = 0;
  int stall_cycles  = 0;
  int issued_cnt    = 0;
  bit reverse_mode  = 0;
  bit inject_dup    = 0;
  bit prev_stall    = 0;
  logic [31:0]      prev_addr = '0;
  logic [TAG_W-1:0] prev_tag = '0;
  logic [DW-1:0]    last_exp = '0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  // Backing memory contents: two fixed words for the 6-byte case, address-derived elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_2000) return 32'hAABBCCDD;
    if (a == 32'h0000_2004) return 32'h11223344;
    return {a[15:0] ^ 16'hC3A5, a[15:0] + 16'h0101};
  endfunction

  // Reference result of a fetch, built byte by byte.
  function automatic exp_t model(input logic [31:0] addr, input int size);
    exp_t e;
    int clamped;
    logic [31:0] w;
    clamped  = (size > 48) ? 48 : size;
    e.base   = {addr[31:2], 2'b00};
    e.err    = (size > 48) || (addr[1:0] != 2'b00);
    e.nwords = (clamped + 3) / 4;
    e.data   = '0;
    for (int i = 0; i < clamped; i++) begin
      w = mem_word(e.base + 32'(i / 4) * 4);
      e.data[i*8 +: 8] = w[(i % 4)*8 +: 8];
    end
    return e;
  endfunction

  // Memory model and completion monitor, all evaluated on the falling edge.
  initial begin
    forever begin
      int   avail;
      int   idx;
      bit   all_issued;
      req_t r;
      rsp_t s;
      exp_t e;
      @(negedge clk);
      if (reset) begin
        foreach (pending[i]) stale_q.push_back(pending[i]);
        pending.delete();
        inj_q.delete();
        issued_cnt    = 0;
        prev_stall    = 0;
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
      end else begin
        if (valid_out) begin
          check_val("valid_has_fetch", DW'(sb.size() != 0), DW'(1));
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check_val("data", mem_data, e.data);
            check_val("err", DW'(err_out), DW'(e.err));
            check_val("nreq", DW'(issued_cnt), DW'(e.nwords));
            $display("fetch base=%h words=%0d err=%0b done", e.base, e.nwords, err_out);
            last_exp = e.data;
          end
          issued_cnt = 0;
        end

        mem_req_ready = (stall_cycles == 0);
        if (stall_cycles > 0) stall_cycles--;
        avail = pending.size();
        if (mem_req_valid) begin
          if (prev_stall) begin
            check_val("stall_addr", DW'(mem_req_addr), DW'(prev_addr));
            check_val("stall_tag", DW'(mem_req_tag), DW'(prev_tag));
          end
          prev_stall = !mem_req_ready;
          prev_addr  = mem_req_addr;
          prev_tag   = mem_req_tag;
          if (mem_req_ready) begin
            check_val("req_has_fetch", DW'(sb.size() != 0), DW'(1));
            if (sb.size() != 0) begin
              check_val("req_tag", DW'(mem_req_tag), DW'(issued_cnt));
              check_val("req_addr", DW'(mem_req_addr), DW'(sb[0].base + 32'(issued_cnt) * 4));
            end
            r.addr = mem_req_addr;
            r.tag  = mem_req_tag;
            pending.push_back(r);
            issued_cnt++;
            check_val("in_flight_le4", DW'(pending.size() <= 4), DW'(1));
          end
        end else begin
          prev_stall = 0;
        end

        all_issued    = (sb.size() != 0) && (issued_cnt >= sb[0].nwords);
        mem_rsp_valid = 1'b0;
        if (stale_q.size() > 0) begin
          r = stale_q.pop_front();
          mem_rsp_valid = 1'b1;
          mem_rsp_tag   = r.tag;
          mem_rsp_data  = mem_word(r.addr);
        end else if (inj_q.size() > 0) begin
          s = inj_q.pop_front();
          mem_rsp_valid = 1'b1;
          mem_rsp_tag   = s.tag;
          mem_rsp_data  = s.data;
        end else if (avail > 0 && (!reverse_mode || avail >= 4 || all_issued)) begin
          idx = reverse_mode ? avail - 1 : 0;
          r = pending[idx];
          pending.delete(idx);
          mem_rsp_valid = 1'b1;
          mem_rsp_tag   = r.tag;
          mem_rsp_data  = mem_word(r.addr);
          if (inject_dup && r.tag == '0) begin
            s.tag = TAG_W'(0);  s.data = 32'hDEADBEEF; inj_q.push_back(s);
            s.tag = TAG_W'(14); s.data = 32'hCAFEF00D; inj_q.push_back(s);
            inject_dup = 0;
          end
        end
      end
    end
  end

  // Issue one fetch, optionally poke start while busy, and count cycles to valid_out.
  task automatic run_fetch(input logic [31:0] addr, input int size, input bit busy_poke, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!ready_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    sb.push_back(model(addr, size));
    mem_addr = addr;
    mem_size = SIZE_W'(size);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!valid_out && lat < 300) begin
      if (busy_poke && lat == 2) begin
        start    = 1'b1;
        mem_addr = 32'h0000_7000;
        mem_size = SIZE_W'(8);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check_val("done_seen", DW'(valid_out), DW'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    #3;
    check_val("rst_ready", DW'(ready_out), DW'(1));
    check_val("rst_valid", DW'(valid_out), DW'(0));
    check_val("rst_err", DW'(err_out), DW'(0));
    check_val("rst_req_valid", DW'(mem_req_valid), DW'(0));
    check_val("rst_data", mem_data, DW'(0));
    check_val("rsp_ready", DW'(mem_rsp_ready), DW'(1));
    @(negedge clk);
    #2 reset = 1'b0;

    // 32 B BVH node, in order
    run_fetch(32'h0000_1000, 32, 0, lat);
    @(negedge clk);
    check_val("pulse_one_cycle", DW'(valid_out), DW'(0));
    check_val("ready_after_done", DW'(ready_out), DW'(1));
    @(negedge clk);
    check_val("data_hold", mem_data, last_exp);

    // 48 B in order, then reverse order
    run_fetch(32'h0000_1000, 48, 0, lat);
    reverse_mode = 1;
    run_fetch(32'h0000_1000, 48, 0, lat);
    reverse_mode = 0;

    // 6 B with tail-byte masking
    run_fetch(32'h0000_2000, 6, 0, lat);
    check_val("six_byte_low", DW'(mem_data[63:0]), DW'(64'h00003344_AABBCCDD));

    // Oversize and misaligned requests
    run_fetch(32'h0000_4000, 60, 0, lat);
    run_fetch(32'h0000_1002, 4, 0, lat);

    // Back-pressure, duplicate/out-of-range tags, start while busy
    stall_cycles = 6;
    inject_dup   = 1;
    run_fetch(32'h0000_5000, 16, 1, lat);
    repeat (10) @(negedge clk);
    check_val("idle_after_poke", DW'(ready_out), DW'(1));

    // Reset in the middle of a 48 B fetch
    reverse_mode = 1;
    @(negedge clk);
    sb.push_back(model(32'h0000_6000, 48));
    mem_addr = 32'h0000_6000;
    mem_size = SIZE_W'(48);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("mid_rst_ready", DW'(ready_out), DW'(1));
    check_val("mid_rst_valid", DW'(valid_out), DW'(0));
    check_val("mid_rst_err", DW'(err_out), DW'(0));
    check_val("mid_rst_req_valid", DW'(mem_req_valid), DW'(0));
    check_val("mid_rst_data", mem_data, DW'(0));
    sb.delete();
    @(negedge clk);
    #2 reset = 1'b0;
    reverse_mode = 0;
    repeat (8) @(negedge clk);
    check_val("stale_dropped_data", mem_data, DW'(0));
    check_val("stale_ready", DW'(ready_out), DW'(1));

    // Fresh 4 B fetch with minimum latency
    run_fetch(32'h0000_8000, 4, 0, lat);
    check_val("latency_1word", DW'(lat), DW'(3));

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
